// File: rtl/if_stage_prefetch.sv
// Instruction-fetch stage with a prefetch queue.
// Issues sequential fetches with several requests in flight, keeps each request's
// address in a small tag FIFO so it can be paired with its in-order response, and
// buffers {pc, instruction} pairs in a DEPTH-entry queue read by ID.
// Handshake: a fetch is transferred on a rising edge where mem_req_o && mem_gnt_i;
// mem_addr_o holds while mem_req_o waits for a grant. Responses carry no handshake:
// each mem_rvalid_i cycle retires the oldest request in flight.
module if_stage_prefetch #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 4,
    parameter int                MAX_OUTST = 2,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                PC_STEP   = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              freeze_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] branch_addr_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0] instruction_o,
    output logic              valid_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int TW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] q_pc_q   [DEPTH];
    logic [DATA_W-1:0] q_data_q [DEPTH];
    logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic [OW-1:0]     outst_q, outst_d;
    logic [OW-1:0]     drop_q, drop_d;
    logic [ADDR_W-1:0] tag_q [MAX_OUTST];
    logic [TW-1:0]     tag_rd_q, tag_wr_q, tag_rd_nxt, tag_wr_nxt;

    logic can_issue, grant, push, pop;

    // Credits: every request in flight owns a queue slot, so a response can always be pushed.
    assign can_issue  = (int'(count_q) + int'(outst_q) < DEPTH) && (int'(outst_q) < MAX_OUTST);
    assign mem_req_o  = !rst_i && !branch_taken_i && can_issue;
    assign mem_addr_o = fetch_pc_q;
    assign grant      = mem_req_o && mem_gnt_i;

    assign push = mem_rvalid_i && (drop_q == '0) && !branch_taken_i;
    assign pop  = valid_o && !freeze_i && !branch_taken_i;

    assign valid_o       = (count_q != '0);
    assign pc_o          = q_pc_q[rd_ptr_q];
    assign instruction_o = q_data_q[rd_ptr_q];

    assign tag_wr_nxt = (tag_wr_q == TW'(MAX_OUTST - 1)) ? '0 : tag_wr_q + 1'b1;
    assign tag_rd_nxt = (tag_rd_q == TW'(MAX_OUTST - 1)) ? '0 : tag_rd_q + 1'b1;

    // Next-state for fetch PC, occupancy, in-flight and squash counters.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (branch_taken_i)
            fetch_pc_d = branch_addr_i;
        else if (grant)
            fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);

        outst_d = outst_q;
        if (grant && !mem_rvalid_i)
            outst_d = outst_q + 1'b1;
        else if (!grant && mem_rvalid_i)
            outst_d = outst_q - 1'b1;

        // No grant can coincide with a branch, so outst_d is exactly what is still
        // in flight after this edge; all of it belongs to the old path.
        drop_d = drop_q;
        if (branch_taken_i)
            drop_d = outst_d;
        else if (mem_rvalid_i && (drop_q != '0))
            drop_d = drop_q - 1'b1;

        count_d = count_q;
        if (branch_taken_i)
            count_d = '0;
        else if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
    end

    // Control registers: PC, queue pointers, counters and tag FIFO pointers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            tag_rd_q   <= '0;
            tag_wr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            if (branch_taken_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (grant)        tag_wr_q <= tag_wr_nxt;
            if (mem_rvalid_i) tag_rd_q <= tag_rd_nxt;
        end
    end

    // Queue storage; cleared on reset so pc_o/instruction_o read zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_pc_q[i]   <= '0;
                q_data_q[i] <= '0;
            end
        end else if (push) begin
            q_pc_q[wr_ptr_q]   <= tag_q[tag_rd_q];
            q_data_q[wr_ptr_q] <= mem_rdata_i;
        end
    end

    // Tag FIFO: address of each granted request, retired by its response.
    always_ff @(posedge clk_i) begin
        if (grant)
            tag_q[tag_wr_q] <= fetch_pc_q;
    end

    // A response with nothing in flight means the memory side is out of step.
    always_ff @(posedge clk_i) begin
        if (!rst_i && mem_rvalid_i)
            assert (outst_q != '0);
    end

endmodule

// File: tb/tb_if_stage_prefetch.sv
// Directed bench for if_stage_prefetch with a behavioural in-order memory.
module tb_if_stage_prefetch;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          freeze = 1'b0;
    logic          branch_taken = 1'b0;
    logic [AW-1:0] branch_addr = '0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_gnt = 1'b0;
    logic          mem_rvalid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic [AW-1:0] pc;
    logic [DW-1:0] instruction;
    logic          valid;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bit gnt_en = 1'b1;
    int lat    = 1;

    logic [AW-1:0] rsp_addr_q[$];
    int            rsp_due_q[$];
    logic [AW-1:0] got_pc_q[$];
    logic [DW-1:0] got_ins_q[$];

    logic          pre_req;
    logic [AW-1:0] pre_addr;

    if_stage_prefetch dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .freeze_i       (freeze),
        .branch_taken_i (branch_taken),
        .branch_addr_i  (branch_addr),
        .mem_req_o      (mem_req),
        .mem_addr_o     (mem_addr),
        .mem_gnt_i      (mem_gnt),
        .mem_rvalid_i   (mem_rvalid),
        .mem_rdata_i    (mem_rdata),
        .pc_o           (pc),
        .instruction_o  (instruction),
        .valid_o        (valid)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] instr_of(input logic [AW-1:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // One cycle: drive memory side, sample pre-edge view, clock, return at negedge.
    task automatic tick();
        if (rst) begin
            rsp_addr_q.delete();
            rsp_due_q.delete();
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end else if (rsp_due_q.size() > 0 && rsp_due_q[0] <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = instr_of(rsp_addr_q[0]);
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end
        mem_gnt = gnt_en;
        #1;
        pre_req  = mem_req;
        pre_addr = mem_addr;
        if (mem_req && mem_gnt) begin
            rsp_addr_q.push_back(mem_addr);
            rsp_due_q.push_back(cyc + lat);
        end
        if (mem_rvalid) begin
            void'(rsp_addr_q.pop_front());
            void'(rsp_due_q.pop_front());
        end
        if (valid && !freeze && !branch_taken && !rst) begin
            got_pc_q.push_back(pc);
            got_ins_q.push_back(instruction);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset(input int l);
        lat = l;
        gnt_en = 1'b1;
        freeze = 1'b0;
        branch_taken = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        got_pc_q.delete();
        got_ins_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        gnt_en = 1'b1;
        tick();
        n_checks++; if (pre_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", pre_req); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
        n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", pc); end
        n_checks++; if (instruction !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", instruction); end
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            n_fail++; $display("FAIL reset_first_req: got req=%b addr=%h expected req=1 addr=0", mem_req, mem_addr);
        end
    endtask

    task automatic test_sequential();
        do_reset(1);
        tick();
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL seq_latency_early: got valid=%b expected 0", valid); end
        tick();
        n_checks++; if (valid !== 1'b1 || pc !== 32'h0 || instruction !== instr_of(32'h0)) begin
            n_fail++; $display("FAIL seq_first: got valid=%b pc=%h ins=%h expected 1 0 %h", valid, pc, instruction, instr_of(32'h0));
        end
        for (int i = 0; i < 8; i++) tick();
        n_checks++; if (got_pc_q.size() != 8) begin n_fail++; $display("FAIL seq_count: got %0d expected 8", got_pc_q.size()); end
        for (int i = 0; i < got_pc_q.size(); i++) begin
            n_checks++; if (got_pc_q[i] !== 32'(4 * i) || got_ins_q[i] !== instr_of(32'(4 * i))) begin
                n_fail++; $display("FAIL seq_pc[%0d]: got pc=%h ins=%h expected pc=%h", i, got_pc_q[i], got_ins_q[i], 4 * i);
            end
        end
    endtask

    task automatic test_freeze();
        bit exp_req[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        do_reset(1);
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if (got_pc_q.size() != 2 || pc !== 32'h8) begin
            n_fail++; $display("FAIL frz_start: got pops=%0d pc=%h expected 2 8", got_pc_q.size(), pc);
        end
        freeze = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++; if (pre_req !== exp_req[i]) begin n_fail++; $display("FAIL frz_req[%0d]: got %b expected %b", i, pre_req, exp_req[i]); end
            n_checks++; if (valid !== 1'b1 || pc !== 32'h8 || instruction !== instr_of(32'h8)) begin
                n_fail++; $display("FAIL frz_hold[%0d]: got valid=%b pc=%h ins=%h expected 1 8", i, valid, pc, instruction);
            end
        end
        freeze = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        n_checks++; if (got_pc_q.size() != 12) begin n_fail++; $display("FAIL frz_count: got %0d expected 12", got_pc_q.size()); end
        for (int i = 0; i < got_pc_q.size(); i++) begin
            n_checks++; if (got_pc_q[i] !== 32'(4 * i) || got_ins_q[i] !== instr_of(32'(4 * i))) begin
                n_fail++; $display("FAIL frz_pc[%0d]: got pc=%h expected %h", i, got_pc_q[i], 4 * i);
            end
        end
    endtask

    task automatic test_branch();
        do_reset(3);
        tick();
        tick();
        branch_taken = 1'b1;
        branch_addr  = 32'h100;
        tick();
        branch_taken = 1'b0;
        n_checks++; if (pre_req !== 1'b0) begin n_fail++; $display("FAIL br_req_blocked: got %b expected 0", pre_req); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL br_flush: got valid=%b expected 0", valid); end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 1) begin
                n_checks++; if (pre_req !== 1'b1 || pre_addr !== 32'h100) begin
                    n_fail++; $display("FAIL br_target_req: got req=%b addr=%h expected 1 100", pre_req, pre_addr);
                end
            end
            n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL br_squash[%0d]: got valid=%b pc=%h expected valid 0", i, valid, pc); end
        end
        tick();
        n_checks++; if (valid !== 1'b1 || pc !== 32'h100 || instruction !== instr_of(32'h100)) begin
            n_fail++; $display("FAIL br_first: got valid=%b pc=%h ins=%h expected 1 100", valid, pc, instruction);
        end
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if (got_pc_q.size() < 2) begin n_fail++; $display("FAIL br_count: got %0d expected >=2", got_pc_q.size()); end
        for (int i = 0; i < got_pc_q.size(); i++) begin
            n_checks++; if (got_pc_q[i] !== 32'h100 + 32'(4 * i)) begin
                n_fail++; $display("FAIL br_pc[%0d]: got %h expected %h", i, got_pc_q[i], 32'h100 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_gnt_stall();
        do_reset(4);
        gnt_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (pre_req !== 1'b1 || pre_addr !== 32'h0) begin
                n_fail++; $display("FAIL stall_addr[%0d]: got req=%b addr=%h expected 1 0", i, pre_req, pre_addr);
            end
        end
        gnt_en = 1'b1;
        for (int i = 0; i < 24; i++) tick();
        n_checks++; if (got_pc_q.size() != 8) begin n_fail++; $display("FAIL stall_count: got %0d expected 8", got_pc_q.size()); end
        for (int i = 0; i < got_pc_q.size(); i++) begin
            n_checks++; if (got_pc_q[i] !== 32'(4 * i) || got_ins_q[i] !== instr_of(32'(4 * i))) begin
                n_fail++; $display("FAIL stall_pc[%0d]: got pc=%h ins=%h expected pc=%h", i, got_pc_q[i], got_ins_q[i], 4 * i);
            end
        end
    endtask

    task automatic test_freeze_branch();
        do_reset(1);
        freeze = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        n_checks++; if (pre_req !== 1'b0 || valid !== 1'b1 || pc !== 32'h0) begin
            n_fail++; $display("FAIL fb_full: got req=%b valid=%b pc=%h expected 0 1 0", pre_req, valid, pc);
        end
        branch_taken = 1'b1;
        branch_addr  = 32'h400;
        tick();
        branch_taken = 1'b0;
        freeze = 1'b0;
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL fb_flush: got valid=%b expected 0", valid); end
        tick();
        n_checks++; if (pre_req !== 1'b1 || pre_addr !== 32'h400) begin
            n_fail++; $display("FAIL fb_target_req: got req=%b addr=%h expected 1 400", pre_req, pre_addr);
        end
        tick();
        n_checks++; if (valid !== 1'b1 || pc !== 32'h400 || instruction !== instr_of(32'h400)) begin
            n_fail++; $display("FAIL fb_first: got valid=%b pc=%h ins=%h expected 1 400", valid, pc, instruction);
        end
    endtask

    task automatic test_back_to_back();
        do_reset(1);
        for (int i = 0; i < 3; i++) tick();
        branch_taken = 1'b1;
        branch_addr  = 32'h200;
        tick();
        branch_addr  = 32'h300;
        tick();
        branch_taken = 1'b0;
        got_pc_q.delete();
        got_ins_q.delete();
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if (got_pc_q.size() != 2) begin n_fail++; $display("FAIL b2b_count: got %0d expected 2", got_pc_q.size()); end
        for (int i = 0; i < got_pc_q.size(); i++) begin
            n_checks++; if (got_pc_q[i] !== 32'h300 + 32'(4 * i)) begin
                n_fail++; $display("FAIL b2b_pc[%0d]: got %h expected %h", i, got_pc_q[i], 32'h300 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_wrap_reset();
        do_reset(1);
        branch_taken = 1'b1;
        branch_addr  = 32'hFFFF_FFFC;
        tick();
        branch_taken = 1'b0;
        tick();
        tick();
        n_checks++; if (pre_req !== 1'b1 || pre_addr !== 32'h0) begin
            n_fail++; $display("FAIL wrap_addr: got req=%b addr=%h expected 1 0", pre_req, pre_addr);
        end
        tick();
        tick();
        tick();
        n_checks++; if (got_pc_q.size() != 3) begin n_fail++; $display("FAIL wrap_count: got %0d expected 3", got_pc_q.size()); end
        if (got_pc_q.size() == 3) begin
            n_checks++; if (got_pc_q[0] !== 32'hFFFF_FFFC || got_pc_q[1] !== 32'h0 || got_pc_q[2] !== 32'h4) begin
                n_fail++; $display("FAIL wrap_seq: got %h %h %h expected fffffffc 0 4", got_pc_q[0], got_pc_q[1], got_pc_q[2]);
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (valid !== 1'b0 || pc !== 32'h0) begin
            n_fail++; $display("FAIL mid_rst: got valid=%b pc=%h expected 0 0", valid, pc);
        end
        got_pc_q.delete();
        got_ins_q.delete();
        tick();
        tick();
        n_checks++; if (valid !== 1'b1 || pc !== 32'h0 || instruction !== instr_of(32'h0)) begin
            n_fail++; $display("FAIL rst_restart: got valid=%b pc=%h ins=%h expected 1 0", valid, pc, instruction);
        end
        tick();
        n_checks++; if (got_pc_q.size() != 1 || got_pc_q[0] !== 32'h0) begin
            n_fail++; $display("FAIL rst_first_pop: got n=%0d expected one pop of pc 0", got_pc_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_freeze();
        test_branch();
        test_gnt_stall();
        test_freeze_branch();
        test_back_to_back();
        test_wrap_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
